alu_pipe: RTL and testbench

Parametrised, handshaked ALU that generalises the team's 4-bit combinational ALU to WIDTH bits and registers its outputs. It adds shift and multiply opcodes and valid/ready flow control on both sides. Single-cycle ops sustain one result per clock. MUL runs on an iterative shift-add engine over WIDTH cycles. It sits between the operand-issue logic and the writeback stage, and either side may stall it.

---
 rtl/alu_pkg.sv | 18 +
 rtl/alu_mul_seq.sv | 57 +++++
 rtl/alu_pipe.sv | 146 ++++++++++++++
 tb/tb_alu_pipe.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the pipelined ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial product per clock over WIDTH
// cycles. A start pulse latches the operands and clears the accumulator; done
// pulses for one cycle once the final partial product has been added.
module alu_mul_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [2*WIDTH-1:0] a_ext;
  logic [WIDTH-1:0]   b_r;
  logic [SHW-1:0]     cnt;
  logic               busy;

  // Operand latch, iteration counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here is updated with <= so all of them see the
    // pre-edge values of one another, exactly as the flops will.
    if (!rst_n) begin
      a_ext   <= '0;
      b_r     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else if (start) begin
      a_ext   <= {{WIDTH{1'b0}}, a};
      b_r     <= b;
      cnt     <= '0;
      busy    <= 1'b1;
      done    <= 1'b0;
      product <= '0;
    end else if (busy) begin
      if (b_r[cnt]) begin
        product <= product + (a_ext << cnt);
      end
      if (cnt == CNT_LAST) begin
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        cnt <= cnt + SHW'(1);
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit ALU with a registered result. Single-cycle ops retire
// through the output register the edge they are accepted; MUL is handed to
// the iterative engine and its product is loaded when the engine finishes.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALU_CTRL,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] RESULT,
  output logic             CARRY_OUT,
  output logic             ZERO,
  output logic             OVERFLOW
);

  state_t state, state_next;

  logic               accept;
  logic               mul_start;
  logic               mul_load;
  logic               mul_done;
  logic [2*WIDTH-1:0] product;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_diff;
  logic [SHW-1:0]     shamt;
  logic [WIDTH-1:0]   sc_result;
  logic               sc_carry;
  logic               sc_ovf;

  logic               load;
  logic [WIDTH-1:0]   load_result;
  logic               load_carry;
  logic               load_ovf;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next state and input-side handshake; an output stall blocks new work.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch forms.
    state_next = state;
    in_ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = ~out_valid | out_ready;
        if (in_valid && in_ready && ALU_CTRL == OP_MUL) state_next = ST_MUL;
      end
      ST_MUL: begin
        if (mul_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign mul_start = accept & (ALU_CTRL == OP_MUL);
  assign mul_load  = (state == ST_MUL) & mul_done;
  assign load      = mul_load | (accept & ~mul_start);

  alu_mul_seq #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (A),
    .b       (B),
    .done    (mul_done),
    .product (product)
  );

  // Single-cycle datapath; flags default to 0 for the logic and shift ops.
  always_comb begin
    add_sum   = {1'b0, A} + {1'b0, B};
    sub_diff  = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
    shamt     = B[SHW-1:0];
    sc_result = '0;
    sc_carry  = 1'b0;
    sc_ovf    = 1'b0;
    case (ALU_CTRL)
      OP_ADD: begin
        sc_result = add_sum[WIDTH-1:0];
        sc_carry  = add_sum[WIDTH];
        sc_ovf    = (A[WIDTH-1] == B[WIDTH-1]) & (sc_result[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        sc_result = sub_diff[WIDTH-1:0];
        sc_carry  = sub_diff[WIDTH];
        sc_ovf    = (A[WIDTH-1] != B[WIDTH-1]) & (sc_result[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  sc_result = A & B;
      OP_OR:   sc_result = A | B;
      OP_XOR:  sc_result = A ^ B;
      OP_SHL:  sc_result = A << shamt;
      OP_SHR:  sc_result = A >> shamt;
      default: sc_result = '0;
    endcase
  end

  // Select what the output register captures: finished product or ALU result.
  always_comb begin
    if (mul_load) begin
      load_result = product[WIDTH-1:0];
      load_carry  = |product[2*WIDTH-1:WIDTH];
      load_ovf    = 1'b0;
    end else begin
      load_result = sc_result;
      load_carry  = sc_carry;
      load_ovf    = sc_ovf;
    end
  end

  // Output register: a load wins over a drain on the same edge; a stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      RESULT    <= '0;
      CARRY_OUT <= 1'b0;
      ZERO      <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      RESULT    <= load_result;
      CARRY_OUT <= load_carry;
      ZERO      <= (load_result == '0);
      OVERFLOW  <= load_ovf;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe at WIDTH=8: directed vectors with fixed
// expected values, then a randomized stream scored against an arithmetic model.
module tb_alu_pipe;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALU_CTRL;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] RESULT;
  logic             CARRY_OUT;
  logic             ZERO;
  logic             OVERFLOW;

  int checks = 0;
  int errors = 0;
  int drains = 0;

  typedef struct {
    logic [2:0] op;
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       v;
  } exp_t;

  exp_t       q[$];
  logic       held;
  logic [10:0] held_val;

  alu_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .ALU_CTRL  (ALU_CTRL),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .RESULT    (RESULT),
    .CARRY_OUT (CARRY_OUT),
    .ZERO      (ZERO),
    .OVERFLOW  (OVERFLOW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, signed overflow judged by range.
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ua, ub, sa, sb, full;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    e.op = op;
    e.c  = 1'b0;
    e.v  = 1'b0;
    full = 0;
    case (op)
      3'd0: begin
        full = ua + ub;
        e.c  = (full > 255);
        e.v  = (sa + sb > 127) || (sa + sb < -128);
      end
      3'd1: begin
        full = (ua - ub + 256) % 256;
        e.c  = (ua >= ub);
        e.v  = (sa - sb > 127) || (sa - sb < -128);
      end
      3'd2:    full = int'(a & b);
      3'd3:    full = int'(a | b);
      3'd4:    full = int'(a ^ b);
      3'd5:    full = ua * (1 << (ub % 8));
      3'd6:    full = ua / (1 << (ub % 8));
      default: begin
        full = ua * ub;
        e.c  = (full > 255);
      end
    endcase
    e.r = 8'(full % 256);
    e.z = (e.r == 8'h00);
    return e;
  endfunction

  // One clock of stimulus from just after a falling edge; scores any transfer.
  task automatic cycle(input logic iv, input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ordy, output logic acc);
    exp_t e;
    in_valid  = iv;
    ALU_CTRL  = op;
    A         = a;
    B         = b;
    out_ready = ordy;
    #1;
    acc = iv & in_ready;
    if (out_valid && out_ready) begin
      drains++;
      if (q.size() == 0) begin
        check("output_without_accept", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        check($sformatf("result_op%0d", e.op), 32'(RESULT), 32'(e.r));
        check($sformatf("carry_op%0d", e.op), 32'(CARRY_OUT), 32'(e.c));
        check($sformatf("zero_op%0d", e.op), 32'(ZERO), 32'(e.z));
        check($sformatf("overflow_op%0d", e.op), 32'(OVERFLOW), 32'(e.v));
      end
    end
    if (out_valid && !out_ready) begin
      check("stall_in_ready", 32'(in_ready), 32'd0);
      if (held) check("stall_hold", 32'({CARRY_OUT, ZERO, OVERFLOW, RESULT}), 32'(held_val));
      held     = 1'b1;
      held_val = {CARRY_OUT, ZERO, OVERFLOW, RESULT};
    end else begin
      held = 1'b0;
    end
    if (acc) q.push_back(model(op, a, b));
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drain everything outstanding with out_ready high, bounded.
  task automatic flush();
    logic acc;
    for (int i = 0; i < 60 && (q.size() != 0 || out_valid); i++) begin
      cycle(1'b0, 3'd0, 8'h00, 8'h00, 1'b1, acc);
    end
    check("flush_empty", 32'(q.size()), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
  endtask

  // Directed single op from an idle, empty pipe with fixed expected values.
  task automatic run_op(input string name, input logic [2:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] er, input logic ec,
                        input logic ez, input logic ev);
    int   edges;
    logic ir_bad;
    in_valid  = 1'b1;
    ALU_CTRL  = op;
    A         = a;
    B         = b;
    out_ready = 1'b1;
    #1;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    A        = $urandom;
    B        = $urandom;
    edges    = 0;
    ir_bad   = 1'b0;
    while (!out_valid && edges < 20) begin
      #1;
      if (in_ready) ir_bad = 1'b1;
      @(posedge clk);
      @(negedge clk);
      edges++;
    end
    check({name, "_latency"}, 32'(edges), (op == 3'd7) ? 32'(WIDTH + 1) : 32'd0);
    check({name, "_busy_in_ready"}, 32'(ir_bad), 32'd0);
    check({name, "_result"}, 32'(RESULT), 32'(er));
    check({name, "_flags"}, 32'({CARRY_OUT, ZERO, OVERFLOW}), 32'({ec, ez, ev}));
    @(posedge clk);
    @(negedge clk);
    check({name, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic acc;
    int   accepts;
    int   d0;
    logic saw_valid;

    held      = 1'b0;
    held_val  = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    A         = 8'h5A;
    B         = 8'h3C;
    ALU_CTRL  = 3'd0;
    out_ready = 1'b1;

    // Reset held with in_valid asserted: nothing may come out.
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_outputs", 32'({CARRY_OUT, ZERO, OVERFLOW, RESULT}), 32'd0);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Directed boundary vectors.
    run_op("add_7f_01", 3'd0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    run_op("add_ff_01", 3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("sub_05_05", 3'd1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("sub_00_01", 3'd1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("sub_80_01", 3'd1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b0, 1'b1);
    run_op("shl_81_09", 3'd5, 8'h81, 8'h09, 8'h02, 1'b0, 1'b0, 1'b0);
    run_op("shr_a5_08", 3'd6, 8'hA5, 8'h08, 8'hA5, 1'b0, 1'b0, 1'b0);
    run_op("mul_10_20", 3'd7, 8'h10, 8'h20, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("mul_0f_03", 3'd7, 8'h0F, 8'h03, 8'h2D, 1'b0, 1'b0, 1'b0);

    // Back-to-back XOR stream: one accept and, after the first, one result per clock.
    accepts = 0;
    d0      = drains;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 3'd4, 8'($urandom), 8'($urandom), 1'b1, acc);
      if (acc) accepts++;
    end
    check("stream_accepts", 32'(accepts), 32'd8);
    check("stream_drains", 32'(drains - d0), 32'd7);

    // Consumer stalls three cycles, then the stream resumes.
    accepts = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 3'd4, 8'($urandom), 8'($urandom), 1'b0, acc);
      if (acc) accepts++;
    end
    check("stall_accepts", 32'(accepts), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 3'd4, 8'($urandom), 8'($urandom), 1'b1, acc);
    flush();

    // Randomized mix of all opcodes with random valid/ready on both sides.
    for (int i = 0; i < 300; i++) begin
      cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
            8'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    flush();

    // Reset during the fourth cycle of a MUL: no result may appear.
    in_valid  = 1'b1;
    ALU_CTRL  = 3'd7;
    A         = 8'h33;
    B         = 8'h07;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_idle_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("abort_no_output", 32'(saw_valid), 32'd0);
    run_op("add_after_abort", 3'd0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
